conv_mac: RTL and testbench

//  Consumes 5x5 pixel windows from conv and produces one filtered pixel per window.

---
 rtl/conv_pkg.sv | 25 ++
 rtl/conv_mac_coeff.sv | 50 +++++
 rtl/conv_mac.sv | 164 ++++++++++++++++
 tb/tb_conv_mac.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution datapath.
// Holds the kernel layout, coefficient bank types and the identity-bank helper.
package conv_pkg;

    localparam int CONV_PIXEL_W = 8;
    localparam int CONV_COEFF_W = 8;
    localparam int KERNEL_TAPS  = 25;
    localparam int CENTER_TAP   = 12;
    localparam int MAC_P_W      = CONV_PIXEL_W + CONV_COEFF_W + 1;
    localparam int MAC_ACC_W    = MAC_P_W + 5;

    typedef logic [CONV_PIXEL_W-1:0]        pixel_t;
    typedef pixel_t [KERNEL_TAPS-1:0]       kernel_t;
    typedef logic signed [CONV_COEFF_W-1:0] coeff_t;
    typedef coeff_t [KERNEL_TAPS-1:0]       coeff_bank_t;

    // Pass-through kernel: only the centre tap is set, scaled to cancel the output shift.
    function automatic coeff_bank_t identity_bank(input int shift);
        coeff_bank_t bank;
        bank             = '0;
        bank[CENTER_TAP] = coeff_t'(CONV_COEFF_W'(1) << shift);
        return bank;
    endfunction

endpackage

// File: rtl/conv_mac_coeff.sv
// Coefficient storage for conv_mac: shadow bank written by cfg, active bank used by S1,
// and the commit/pending logic that decides when the shadow bank takes over.
module conv_mac_coeff
    import conv_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        cfg_we_i,
    input  logic [4:0]  cfg_addr_i,
    input  coeff_t      cfg_data_i,
    input  logic        cfg_commit_i,
    input  logic        sof_accept_i,
    input  logic        pipe_idle_i,
    output coeff_bank_t bank_o,
    output logic        cfg_pend_o
);

    coeff_bank_t shadow_r;
    coeff_bank_t active_r;
    logic        pend_r;
    logic        swap_s;

    assign swap_s = pend_r & (sof_accept_i | pipe_idle_i);

    // A window accepted in the swap cycle must already multiply with the new bank.
    assign bank_o     = swap_s ? shadow_r : active_r;
    assign cfg_pend_o = pend_r;

    // Shadow writes, bank swap and pending flag; a write in the swap cycle reaches only the shadow.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            shadow_r <= identity_bank(SHIFT);
            active_r <= identity_bank(SHIFT);
            pend_r   <= 1'b0;
        end else begin
            if (cfg_we_i && (cfg_addr_i <= 5'd24)) begin
                shadow_r[cfg_addr_i] <= cfg_data_i;
            end
            if (swap_s) begin
                active_r <= shadow_r;
                pend_r   <= 1'b0;
            end else if (cfg_commit_i) begin
                pend_r   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_mac.sv
// 5x5 multiply-accumulate filter: multiply, row sums, final sum with round/shift/saturate,
// then an output register; all stages stall together on downstream backpressure.
module conv_mac
    import conv_pkg::*;
#(
    parameter int PIXEL_W = CONV_PIXEL_W,
    parameter int COEFF_W = CONV_COEFF_W,
    parameter int SHIFT   = 4
) (
    input  logic                           clk,
    input  logic                           arst,
    input  logic                           s_tvalid_i,
    input  logic [KERNEL_TAPS*PIXEL_W-1:0] s_tdata_i,
    input  logic                           s_tuser_i,
    input  logic                           s_tlast_i,
    output logic                           s_tready_o,
    output logic                           m_tvalid_o,
    output logic [PIXEL_W-1:0]             m_tdata_o,
    output logic                           m_tuser_o,
    output logic                           m_tlast_o,
    input  logic                           m_tready_i,
    input  logic                           cfg_we_i,
    input  logic [4:0]                     cfg_addr_i,
    input  logic signed [COEFF_W-1:0]      cfg_data_i,
    input  logic                           cfg_commit_i,
    output logic                           cfg_pend_o
);

    localparam int P_W    = PIXEL_W + COEFF_W + 1;
    localparam int ACC_W  = P_W + 5;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] RND     = (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : (ACC_W+1)'(0);
    localparam logic signed [ACC_W:0] PIX_MAX = (ACC_W+1)'({PIXEL_W{1'b1}});

    logic                    en_s;
    logic                    accept_s;
    logic                    pipe_idle_s;
    logic                    sof_accept_s;
    coeff_bank_t             bank_s;

    logic signed [P_W-1:0]   prod_s [KERNEL_TAPS];
    logic signed [P_W-1:0]   prod_r [KERNEL_TAPS];
    logic signed [ACC_W-1:0] row_s  [5];
    logic signed [ACC_W-1:0] row_r  [5];
    logic signed [ACC_W-1:0] acc_s;
    logic signed [ACC_W:0]   rnd_s;
    logic signed [ACC_W:0]   shr_s;
    logic [PIXEL_W-1:0]      sat_s;
    logic [PIXEL_W-1:0]      pix3_r;
    logic [PIXEL_W-1:0]      m_tdata_r;

    logic v1_r, v2_r, v3_r, m_tvalid_r;
    logic u1_r, u2_r, u3_r, m_tuser_r;
    logic l1_r, l2_r, l3_r, m_tlast_r;

    assign en_s         = ~m_tvalid_r | m_tready_i;
    assign s_tready_o   = en_s;
    assign accept_s     = s_tvalid_i & en_s;
    assign sof_accept_s = accept_s & s_tuser_i;
    assign pipe_idle_s  = ~accept_s & ~v1_r & ~v2_r & ~v3_r;

    conv_mac_coeff #(
        .SHIFT        (SHIFT)
    ) u_coeff (
        .clk          (clk),
        .arst         (arst),
        .cfg_we_i     (cfg_we_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_data_i   (cfg_data_i),
        .cfg_commit_i (cfg_commit_i),
        .sof_accept_i (sof_accept_s),
        .pipe_idle_i  (pipe_idle_s),
        .bank_o       (bank_s),
        .cfg_pend_o   (cfg_pend_o)
    );

    // S1 operands: unsigned pixel widened to signed, both sign-extended to product width.
    always_comb begin
        for (int t = 0; t < KERNEL_TAPS; t++) begin
            prod_s[t] = P_W'($signed({1'b0, s_tdata_i[t*PIXEL_W +: PIXEL_W]})) * P_W'(bank_s[t]);
        end
    end

    // S2 row sums of the registered products.
    always_comb begin
        for (int r = 0; r < 5; r++) begin
            row_s[r] = '0;
            for (int c = 0; c < 5; c++) begin
                row_s[r] = row_s[r] + ACC_W'(prod_r[r*5+c]);
            end
        end
    end

    // S3 final sum, round-half-up, arithmetic shift and clamp to pixel range.
    always_comb begin
        acc_s = '0;
        for (int r = 0; r < 5; r++) begin
            acc_s = acc_s + row_r[r];
        end
        rnd_s = (ACC_W+1)'(acc_s) + RND;
        shr_s = rnd_s >>> SHIFT;
        if (shr_s[ACC_W]) begin
            sat_s = '0;
        end else if (shr_s > PIX_MAX) begin
            sat_s = '1;
        end else begin
            sat_s = shr_s[PIXEL_W-1:0];
        end
    end

    // Stage valid bits advance together whenever the pipe is enabled.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            v1_r       <= 1'b0;
            v2_r       <= 1'b0;
            v3_r       <= 1'b0;
            m_tvalid_r <= 1'b0;
        end else if (en_s) begin
            v1_r       <= accept_s;
            v2_r       <= v1_r;
            v3_r       <= v2_r;
            m_tvalid_r <= v3_r;
        end
    end

    // Stage data and sideband load only behind a valid predecessor.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int t = 0; t < KERNEL_TAPS; t++) prod_r[t] <= '0;
            for (int r = 0; r < 5; r++) row_r[r] <= '0;
            pix3_r    <= '0;
            m_tdata_r <= '0;
            {u1_r, u2_r, u3_r, m_tuser_r} <= 4'b0000;
            {l1_r, l2_r, l3_r, m_tlast_r} <= 4'b0000;
        end else if (en_s) begin
            if (accept_s) begin
                for (int t = 0; t < KERNEL_TAPS; t++) prod_r[t] <= prod_s[t];
                u1_r <= s_tuser_i;
                l1_r <= s_tlast_i;
            end
            if (v1_r) begin
                for (int r = 0; r < 5; r++) row_r[r] <= row_s[r];
                u2_r <= u1_r;
                l2_r <= l1_r;
            end
            if (v2_r) begin
                pix3_r <= sat_s;
                u3_r   <= u2_r;
                l3_r   <= l2_r;
            end
            if (v3_r) begin
                m_tdata_r <= pix3_r;
                m_tuser_r <= u3_r;
                m_tlast_r <= l3_r;
            end
        end
    end

    assign m_tvalid_o = m_tvalid_r;
    assign m_tdata_o  = m_tdata_r;
    assign m_tuser_o  = m_tuser_r;
    assign m_tlast_o  = m_tlast_r;

endmodule

// File: tb/tb_conv_mac.sv
// Self-checking bench for conv_mac: random windows and coefficient banks compared
// against an arithmetic reference of the filter and the bank-commit rules.
module tb_conv_mac;

    localparam int SHIFT = 4;

    typedef int bank_arr_t [25];
    typedef struct packed {
        logic [7:0] pix;
        logic       user;
        logic       last;
    } beat_t;

    logic         clk = 1'b0;
    logic         arst = 1'b1;
    logic         s_tvalid_i = 1'b0;
    logic [199:0] s_tdata_i = '0;
    logic         s_tuser_i = 1'b0;
    logic         s_tlast_i = 1'b0;
    logic         s_tready_o;
    logic         m_tvalid_o;
    logic [7:0]   m_tdata_o;
    logic         m_tuser_o;
    logic         m_tlast_o;
    logic         m_tready_i = 1'b1;
    logic         cfg_we_i = 1'b0;
    logic [4:0]   cfg_addr_i = 5'd0;
    logic [7:0]   cfg_data_i = 8'd0;
    logic         cfg_commit_i = 1'b0;
    logic         cfg_pend_o;

    int errors = 0;
    int checks = 0;
    bank_arr_t cur_bank;
    bank_arr_t shadow_model;
    bank_arr_t ident;
    beat_t exp_q[$];
    beat_t obs_q[$];

    always #5 clk = ~clk;

    conv_mac #(.PIXEL_W(8), .COEFF_W(8), .SHIFT(SHIFT)) dut (
        .clk(clk), .arst(arst),
        .s_tvalid_i(s_tvalid_i), .s_tdata_i(s_tdata_i), .s_tuser_i(s_tuser_i),
        .s_tlast_i(s_tlast_i), .s_tready_o(s_tready_o),
        .m_tvalid_o(m_tvalid_o), .m_tdata_o(m_tdata_o), .m_tuser_o(m_tuser_o),
        .m_tlast_o(m_tlast_o), .m_tready_i(m_tready_i),
        .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
        .cfg_commit_i(cfg_commit_i), .cfg_pend_o(cfg_pend_o)
    );

    // Output monitor: a beat transfers at the next rising edge when valid and ready.
    always @(negedge clk) begin
        if (m_tvalid_o === 1'b1 && m_tready_i === 1'b1) begin
            beat_t b;
            b.pix  = m_tdata_o;
            b.user = m_tuser_o;
            b.last = m_tlast_o;
            obs_q.push_back(b);
        end
    end

    function automatic logic [7:0] model_pix(input logic [199:0] win, input bank_arr_t b);
        int sum;
        int r;
        sum = 0;
        for (int t = 0; t < 25; t++) sum += int'(win[t*8 +: 8]) * b[t];
        r = (sum + (1 << (SHIFT - 1))) >>> SHIFT;
        if (r < 0) return 8'd0;
        if (r > 255) return 8'd255;
        return 8'(r);
    endfunction

    function automatic logic [199:0] rand_win();
        logic [199:0] w;
        for (int t = 0; t < 25; t++) w[t*8 +: 8] = 8'($urandom_range(255, 0));
        return w;
    endfunction

    task automatic rand_bank(output bank_arr_t b);
        for (int t = 0; t < 25; t++) b[t] = int'($urandom_range(255, 0)) - 128;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_bank(input bank_arr_t b);
        for (int t = 0; t < 25; t++) begin
            cfg_we_i   = 1'b1;
            cfg_addr_i = 5'(t);
            cfg_data_i = 8'(b[t]);
            tick();
        end
        cfg_we_i = 1'b0;
    endtask

    task automatic do_commit();
        cfg_commit_i = 1'b1;
        tick();
        cfg_commit_i = 1'b0;
    endtask

    task automatic send_win(input logic [199:0] w, input logic u, input logic l);
        bit acc;
        int n;
        beat_t b;
        s_tvalid_i = 1'b1;
        s_tdata_i  = w;
        s_tuser_i  = u;
        s_tlast_i  = l;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = (s_tready_o === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (acc) begin
            b.pix  = model_pix(w, cur_bank);
            b.user = u;
            b.last = l;
            exp_q.push_back(b);
        end else begin
            errors++;
            $display("FAIL accept_timeout: window not accepted after %0d cycles", n);
        end
    endtask

    task automatic wait_results(input int n);
        int k;
        k = 0;
        while (obs_q.size() < n && k < 400) begin
            tick();
            k++;
        end
        repeat (6) tick();
    endtask

    task automatic test_reset();
        logic [199:0] w;
        repeat (3) tick();
        checks += 3;
        if (m_tvalid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: m_tvalid_o=%b, required 0", m_tvalid_o); end
        if (cfg_pend_o !== 1'b0) begin errors++; $display("FAIL reset_pend: cfg_pend_o=%b, required 0", cfg_pend_o); end
        if (s_tready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: s_tready_o=%b, required 1", s_tready_o); end
        arst = 1'b0;
        tick();
        w = {25{8'h33}};
        w[12*8 +: 8] = 8'h80;
        s_tvalid_i = 1'b1;
        s_tdata_i  = w;
        @(negedge clk);
        @(posedge clk);
        #1;
        s_tvalid_i = 1'b0;
        tick();
        tick();
        checks++;
        if (m_tvalid_o !== 1'b0) begin errors++; $display("FAIL latency_early: m_tvalid_o=%b 3 cycles after accept, required 0", m_tvalid_o); end
        tick();
        checks++;
        if ({m_tvalid_o, m_tdata_o} !== {1'b1, 8'h80}) begin
            errors++;
            $display("FAIL latency_identity: valid=%b data=%h, required valid=1 data=80", m_tvalid_o, m_tdata_o);
        end
        repeat (3) tick();
        obs_q.delete();
    endtask

    task automatic test_arith();
        int coef [3] = '{1, 127, -1};
        int pixv [3] = '{16, 255, 100};
        int expv [3] = '{25, 255, 0};
        bank_arr_t b;
        for (int i = 0; i < 3; i++) begin
            for (int t = 0; t < 25; t++) b[t] = coef[i];
            write_bank(b);
            do_commit();
            tick();
            cur_bank = b;
            send_win({25{8'(pixv[i])}}, 1'b0, 1'b0);
            s_tvalid_i = 1'b0;
            wait_results(1);
            checks++;
            if (obs_q.size() !== 1) begin
                errors++;
                $display("FAIL arith_count[%0d]: %0d results, required 1", i, obs_q.size());
            end else if (obs_q[0].pix !== 8'(expv[i])) begin
                errors++;
                $display("FAIL arith_value[%0d]: got %0d, required %0d", i, obs_q[0].pix, expv[i]);
            end
            exp_q.delete();
            obs_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        bank_arr_t rb;
        rand_bank(rb);
        write_bank(rb);
        do_commit();
        tick();
        cur_bank = rb;
        fork
            begin
                repeat (10) tick();
                m_tready_i = 1'b0;
                repeat (5) tick();
                checks++;
                if ({m_tvalid_o, s_tready_o} !== 2'b10) begin
                    errors++;
                    $display("FAIL stall_mid: valid=%b s_tready=%b, required valid=1 s_tready=0", m_tvalid_o, s_tready_o);
                end
                repeat (4) tick();
                checks++;
                if ({m_tvalid_o, s_tready_o} !== 2'b10) begin
                    errors++;
                    $display("FAIL stall_end: valid=%b s_tready=%b, required valid=1 s_tready=0", m_tvalid_o, s_tready_o);
                end
                tick();
                m_tready_i = 1'b1;
            end
        join_none
        for (int i = 0; i < 100; i++) begin
            send_win(rand_win(), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end
        s_tvalid_i = 1'b0;
        wait_results(100);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: %0d results, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_beat[%0d]: got pix=%0d u=%b l=%b, required pix=%0d u=%b l=%b", i,
                         obs_q[i].pix, obs_q[i].user, obs_q[i].last, exp_q[i].pix, exp_q[i].user, exp_q[i].last);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_commit_sof();
        bank_arr_t nb;
        rand_bank(nb);
        write_bank(nb);
        send_win(rand_win(), 1'b0, 1'b0);
        cfg_commit_i = 1'b1;
        send_win(rand_win(), 1'b0, 1'b0);
        cfg_commit_i = 1'b0;
        send_win(rand_win(), 1'b0, 1'b0);
        send_win(rand_win(), 1'b0, 1'b1);
        checks++;
        if (cfg_pend_o !== 1'b1) begin errors++; $display("FAIL sof_pend_held: cfg_pend_o=%b, required 1", cfg_pend_o); end
        cur_bank = nb;
        send_win(rand_win(), 1'b1, 1'b0);
        checks++;
        if (cfg_pend_o !== 1'b0) begin errors++; $display("FAIL sof_pend_clear: cfg_pend_o=%b, required 0", cfg_pend_o); end
        send_win(rand_win(), 1'b0, 1'b0);
        s_tvalid_i = 1'b0;
        wait_results(6);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL sof_count: %0d results, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL sof_beat[%0d]: got pix=%0d u=%b, required pix=%0d u=%b", i,
                         obs_q[i].pix, obs_q[i].user, exp_q[i].pix, exp_q[i].user);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_commit_idle();
        bank_arr_t nb;
        logic [199:0] w;
        int x;
        rand_bank(nb);
        write_bank(nb);
        x = (nb[0] == 99) ? -77 : 99;
        do_commit();
        checks++;
        if (cfg_pend_o !== 1'b1) begin errors++; $display("FAIL idle_pend_set: cfg_pend_o=%b, required 1", cfg_pend_o); end
        cfg_we_i   = 1'b1;
        cfg_addr_i = 5'd0;
        cfg_data_i = 8'(x);
        tick();
        cfg_we_i = 1'b0;
        checks++;
        if (cfg_pend_o !== 1'b0) begin errors++; $display("FAIL idle_pend_clear: cfg_pend_o=%b, required 0", cfg_pend_o); end
        cur_bank     = nb;
        shadow_model = nb;
        shadow_model[0] = x;
        w = rand_win();
        w[7:0] = 8'd200;
        for (int pass = 0; pass < 2; pass++) begin
            send_win(w, 1'b0, 1'b1);
            s_tvalid_i = 1'b0;
            wait_results(1);
            checks++;
            if (obs_q.size() !== 1) begin
                errors++;
                $display("FAIL idle_count[%0d]: %0d results, required 1", pass, obs_q.size());
            end else if (obs_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL idle_value[%0d]: got %0d, required %0d", pass, obs_q[0].pix, exp_q[0].pix);
            end
            exp_q.delete();
            obs_q.delete();
            do_commit();
            tick();
            cur_bank = shadow_model;
        end
    endtask

    task automatic test_reset_midflight();
        bank_arr_t b;
        logic [199:0] w;
        for (int t = 0; t < 25; t++) b[t] = 3;
        write_bank(b);
        send_win(rand_win(), 1'b0, 1'b0);
        send_win(rand_win(), 1'b0, 1'b0);
        cfg_commit_i = 1'b1;
        send_win(rand_win(), 1'b0, 1'b0);
        cfg_commit_i = 1'b0;
        s_tvalid_i   = 1'b0;
        arst = 1'b1;
        #1;
        checks += 2;
        if (m_tvalid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: m_tvalid_o=%b, required 0", m_tvalid_o); end
        if (cfg_pend_o !== 1'b0) begin errors++; $display("FAIL rst_mid_pend: cfg_pend_o=%b, required 0", cfg_pend_o); end
        tick();
        tick();
        arst = 1'b0;
        exp_q.delete();
        repeat (10) tick();
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL rst_stale: %0d stale results, required 0", obs_q.size()); end
        obs_q.delete();
        cur_bank = ident;
        for (int pass = 0; pass < 2; pass++) begin
            w = rand_win();
            send_win(w, 1'b1, 1'b0);
            s_tvalid_i = 1'b0;
            wait_results(1);
            checks++;
            if (obs_q.size() !== 1) begin
                errors++;
                $display("FAIL rst_ident_count[%0d]: %0d results, required 1", pass, obs_q.size());
            end else if (obs_q[0].pix !== w[12*8 +: 8]) begin
                errors++;
                $display("FAIL rst_ident_value[%0d]: got %0d, required %0d", pass, obs_q[0].pix, w[12*8 +: 8]);
            end
            exp_q.delete();
            obs_q.delete();
            do_commit();
            tick();
        end
    endtask

    initial begin
        for (int t = 0; t < 25; t++) ident[t] = 0;
        ident[12] = 1 << SHIFT;
        cur_bank  = ident;
        test_reset();
        test_arith();
        test_back_to_back();
        test_commit_sof();
        test_commit_idle();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
